// File: rtl/multi_rate_divider.sv
// Multi-channel clock-enable tick and 50%-duty square-wave generator with runtime-programmable divisors.
// Latency: every output is registered; a divisor write shows on pending one edge later and takes effect at the next wrap.
// Backpressure: none; writes are always accepted or rejected with a cfg_err pulse, and counting stalls only while en is low.
module multi_rate_divider #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 27,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_DIVS = {27'd100000, 27'd50000000, 27'd100000000}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pending,
  output logic              cfg_err
);

  // A write is legal only for an existing channel and a non-zero divisor.
  logic cfg_ok;
  logic err_q;

  assign cfg_ok  = (int'(cfg_ch) < NUM_CH) && (cfg_div != '0);
  assign cfg_err = err_q;

  // Reject pulse: registered so the error shows in the cycle after the bad write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cfg_we && !cfg_ok;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wr;
    logic             wrap;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   half;

    assign wr      = cfg_we && cfg_ok && (int'(cfg_ch) == c);
    assign wrap    = (cnt_q == div_q - CNT_W'(1));
    assign cnt_nxt = wrap ? '0 : cnt_q + CNT_W'(1);
    // ceil(D/2), one bit wider so D at full scale cannot overflow.
    assign half    = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;

    // Next-state: sync beats en; shadow swaps in only at a period boundary,
    // and a write on that same edge lands in the shadow for the following one.
    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sync) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = 1'b1;
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
      end else if (en) begin
        cnt_d  = cnt_nxt;
        tick_d = (cnt_nxt == '0);
        sq_d   = ({1'b0, cnt_nxt} < half);
        if (wrap && pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
      end
      if (wr) begin
        shd_d  = cfg_div;
        pend_d = 1'b1;
      end
    end

    // Channel state registers; reset restores the power-on divisor.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        div_q  <= INIT_DIVS[c*CNT_W +: CNT_W];
        shd_q  <= INIT_DIVS[c*CNT_W +: CNT_W];
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[c]    = tick_q;
    assign sq[c]      = sq_q;
    assign pending[c] = pend_q;
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Self-checking bench for multi_rate_divider: directed scenarios plus randomized traffic against a period-counting model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every input directly.
module tb_multi_rate_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sync;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  wire  [2:0] tick;
  wire  [2:0] sq;
  wire  [2:0] pending;
  wire        cfg_err;
  wire  [9:0] dvec = {tick, sq, pending, cfg_err};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position inside the current period, active and shadow divisors.
  int         m_cnt [3];
  int         m_d   [3];
  int         m_sh  [3];
  logic [2:0] m_tick, m_sq, m_pend;
  logic       m_err;

  multi_rate_divider #(
    .NUM_CH   (3),
    .CNT_W    (8),
    .INIT_DIVS({8'd1, 8'd6, 8'd4})
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick),
    .sq      (sq),
    .pending (pending),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mvec();
    return {m_tick, m_sq, m_pend, m_err};
  endfunction

  task automatic model_reset();
    m_d    = '{4, 6, 1};
    m_sh   = '{4, 6, 1};
    m_cnt  = '{0, 0, 0};
    m_tick = '0;
    m_sq   = '0;
    m_pend = '0;
    m_err  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (sync) begin
        m_cnt[c]  = 0;
        m_tick[c] = 1'b1;
        m_sq[c]   = 1'b1;
        if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 1'b0; end
      end else if (en) begin
        m_cnt[c] = m_cnt[c] + 1;
        if (m_cnt[c] >= m_d[c]) begin
          m_cnt[c] = 0;
          if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 1'b0; end
        end
        m_tick[c] = (m_cnt[c] == 0);
        m_sq[c]   = (m_cnt[c] < (m_d[c] + 1) / 2);
      end else begin
        m_tick[c] = 1'b0;
      end
      if (cfg_we && int'(cfg_ch) == c && cfg_div != 0) begin
        m_sh[c]   = int'(cfg_div);
        m_pend[c] = 1'b1;
      end
    end
    m_err = cfg_we && (cfg_ch >= 3 || cfg_div == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_div = 8'd0;
    model_reset();
    #1;
    n_chk++;
    if (dvec !== 10'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", dvec, 10'd0); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (dvec !== 10'd0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", dvec, 10'd0); end
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_cadence();
    logic [2:0] et, es;
    for (int k = 1; k <= 12; k++) begin
      step();
      et = {1'b1, (k % 6 == 0), (k % 4 == 0)};
      es = {1'b1, ((k % 6) < 3), ((k % 4) < 2)};
      n_chk++;
      if ({tick, sq, pending} !== {et, es, 3'b000}) begin
        n_fail++; $display("FAIL cadence edge %0d: got %b want %b", k, {tick, sq, pending}, {et, es, 3'b000});
      end
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL cadence_model edge %0d: got %b want %b", k, dvec, mvec()); end
    end
  endtask

  task automatic test_odd_divisor();
    bit found = 0;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd5;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL odd_pending_rise: got %b want 1", pending[0]); end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL odd_model: got %b want %b", dvec, mvec()); end
      if (tick[0]) found = 1;
      else begin
        n_chk++;
        if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL odd_pending_hold: got %b want 1", pending[0]); end
      end
    end
    n_chk++;
    if (!found || pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL odd_wrap: seen %0d pending %b want seen 1 pending 0", found, pending[0]);
    end
    for (int j = 1; j <= 10; j++) begin
      step();
      n_chk++;
      if ({tick[0], sq[0]} !== {(j % 5 == 0), ((j % 5) < 3)}) begin
        n_fail++; $display("FAIL odd_period edge %0d: got %b want %b", j, {tick[0], sq[0]}, {(j % 5 == 0), ((j % 5) < 3)});
      end
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL odd_model2: got %b want %b", dvec, mvec()); end
    end
  endtask

  task automatic test_write_at_wrap();
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd4;
    step();
    cfg_we = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    n_chk++;
    if ({tick, sq, pending[0]} !== 7'b1111110) begin
      n_fail++; $display("FAIL sync_apply: got %b want %b", {tick, sq, pending[0]}, 7'b1111110);
    end
    repeat (3) begin
      step();
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL wrap_pre_model: got %b want %b", dvec, mvec()); end
    end
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd8;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if ({tick[0], pending[0]} !== 2'b11) begin
      n_fail++; $display("FAIL wrap_write_edge: got %b want 11", {tick[0], pending[0]});
    end
    for (int j = 1; j <= 12; j++) begin
      step();
      n_chk++;
      if ({tick[0], pending[0]} !== {(j == 4 || j == 12), (j < 4)}) begin
        n_fail++; $display("FAIL wrap_deferred edge %0d: got %b want %b", j, {tick[0], pending[0]}, {(j == 4 || j == 12), (j < 4)});
      end
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL wrap_model: got %b want %b", dvec, mvec()); end
    end
  endtask

  task automatic test_error();
    logic [2:0] p;
    p = pending;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd0;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if ({cfg_err, pending} !== {1'b1, p}) begin
      n_fail++; $display("FAIL err_div0: got %b want %b", {cfg_err, pending}, {1'b1, p});
    end
    step();
    n_chk++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_div0_clear: got %b want 0", cfg_err); end
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd7;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if ({cfg_err, pending} !== {1'b1, p}) begin
      n_fail++; $display("FAIL err_badch: got %b want %b", {cfg_err, pending}, {1'b1, p});
    end
    step();
    n_chk++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_badch_clear: got %b want 0", cfg_err); end
    repeat (10) begin
      step();
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL err_model: got %b want %b", dvec, mvec()); end
    end
  endtask

  task automatic test_en_sync();
    logic [2:0] s;
    s  = sq;
    en = 1'b0;
    repeat (10) begin
      step();
      n_chk++;
      if ({tick, sq} !== {3'b000, s}) begin
        n_fail++; $display("FAIL en_hold: got %b want %b", {tick, sq}, {3'b000, s});
      end
    end
    en = 1'b1;
    repeat (12) begin
      step();
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL en_resume: got %b want %b", dvec, mvec()); end
    end
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd7;
    step();
    cfg_ch = 3'd2; cfg_div = 8'd3;
    step();
    cfg_we = 1'b0;
    repeat ($urandom_range(1, 9)) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_chk++;
    if ({tick, sq, pending} !== 9'b111111000) begin
      n_fail++; $display("FAIL sync_align: got %b want %b", {tick, sq, pending}, 9'b111111000);
    end
    for (int j = 1; j <= 21; j++) begin
      step();
      n_chk++;
      if (tick !== {(j % 3 == 0), (j % 7 == 0), (j % 8 == 0)}) begin
        n_fail++; $display("FAIL sync_phase edge %0d: got %b want %b", j, tick, {(j % 3 == 0), (j % 7 == 0), (j % 8 == 0)});
      end
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL sync_model: got %b want %b", dvec, mvec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      sync    = ($urandom_range(0, 40) == 0);
      cfg_we  = ($urandom_range(0, 6) == 0);
      cfg_ch  = 3'($urandom_range(0, 3));
      cfg_div = 8'($urandom_range(0, 9));
      step();
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL random_model iter %0d: got %b want %b", i, dvec, mvec()); end
    end
    en = 1'b1; sync = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_async_reset();
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd9;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL ares_pre_pending: got %b want 1", pending[1]); end
    step();
    #3;
    reset = 1'b0;
    #1;
    n_chk++;
    if (dvec !== 10'd0) begin n_fail++; $display("FAIL ares_immediate: got %b want %b", dvec, 10'd0); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (dvec !== 10'd0) begin n_fail++; $display("FAIL ares_hold: got %b want %b", dvec, 10'd0); end
    #4;
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_chk++;
      if ({tick[1:0], pending} !== {(k % 6 == 0), (k % 4 == 0), 3'b000}) begin
        n_fail++; $display("FAIL ares_restart edge %0d: got %b want %b", k, {tick[1:0], pending}, {(k % 6 == 0), (k % 4 == 0), 3'b000});
      end
      n_chk++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL ares_model: got %b want %b", dvec, mvec()); end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_odd_divisor();
    test_write_at_wrap();
    test_error();
    test_en_sync();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_rate_divider.md
# multi_rate_divider

Parametrised successor to the single-output 1 Hz clock divider. Generates `NUM_CH` independent clock-enable ticks and 50%-duty square waves from the one system clock. Divisors can be reprogrammed at runtime, and changes apply glitch-free at period boundaries. Sits between the board clock and the parking controller's timing consumers: 1 Hz occupancy timer, 2 Hz full-lot blink, 1 kHz display refresh.

## Interface
- `NUM_CH`, 3, number of output channels (1..8).
- `CNT_W`, 27, divisor/counter width in bits.
- `INIT_DIVS`, {27'd100000, 27'd50000000, 27'd100000000}, packed `NUM_CH*CNT_W` reset divisors; channel 0 occupies the LSBs.
- `clk`  input  1  system clock, 100 MHz nominal.
- `reset`  input  1  asynchronous, active-low reset; all state is reset while `reset`=0.
- `en`  input  1  global count enable; when low, counters hold.
- `sync`  input  1  synchronous phase-align strobe for all channels.
- `cfg_we`  input  1  divisor write strobe.
- `cfg_ch`  input  3  target channel of the write.
- `cfg_div`  input  `CNT_W`  new divisor value D.
- `tick`  output  `NUM_CH`  one-cycle pulse per period, per channel.
- `sq`  output  `NUM_CH`  square wave per channel.
- `pending`  output  `NUM_CH`  shadow divisor is waiting to be applied.
- `cfg_err`  output  1  one-cycle pulse when a write is rejected.

## Operation
- Per-channel state: `cnt` (`CNT_W`), active divisor `D`, shadow divisor, pending flag, plus registered `tick` and `sq`.
- Reset values:
  - `cnt`=0, `D`=`INIT_DIVS` slice, shadow equals `D`, `pending`=0.
  - `tick`=0, `sq`=0, `cfg_err`=0.
- Enabled edge (`en`=1, `sync`=0):
  - Next count: `cnt_next` = (`cnt`==`D`-1) ? 0 : `cnt`+1.
  - `tick` <= (`cnt_next`==0).
  - `sq` <= (`cnt_next` < ceil(`D`/2)).
- Wrap: the edge where `cnt`==`D`-1. If `pending`=1 at that edge:
  - `D` <= shadow and `pending` <= 0.
  - The new period, starting at `cnt`=0, uses the new `D`.
- Duty cycle: `sq` is high for ceil(D/2) cycles and low for floor(D/2) cycles. The rising edge of `sq` coincides with `tick` for D≥2. For D=1, `tick` and `sq` stay constantly 1.
- `en`=0:
  - `cnt`, `sq`, `D` and `pending` hold; `tick` <= 0.
  - `cfg` writes are still accepted.
- `sync`=1 (overrides `en`):
  - Every channel sets `cnt` <= 0, `tick` <= 1, `sq` <= 1.
  - Any pending shadow is applied immediately.
- Config write (`cfg_we`=1):
  - If `cfg_ch` < `NUM_CH` and `cfg_div` ≠ 0: shadow <= `cfg_div`, `pending` <= 1.
  - Otherwise: the write is dropped, no state changes, and `cfg_err` pulses for 1 cycle.
- Simultaneous events:
  - A write landing on the same edge as that channel's wrap or `sync` is not applied on that edge. It is applied at the next wrap, with `pending` remaining 1.
  - Back-to-back writes before a wrap: the last one wins.
- Counter arithmetic: `cnt`+1 never exceeds `D`-1, and `cnt` never overflows `CNT_W`.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- First `tick` after reset release: high during the cycle following the D-th enabled edge.
- Thereafter, `tick` repeats every D enabled edges.
- Write latency:
  - `pending` rises 1 edge after `cfg_we`.
  - The new `D` takes effect at the first wrap after that edge, so worst case is D_old edges.
- `cfg_err` is high in the cycle after the offending `cfg_we`.
- Reset mid-period: outputs go to their reset values immediately, without waiting for `clk`.
  - Programmed divisors revert to `INIT_DIVS`.
  - Counting restarts from 0 on the first edge after `reset` rises.

## Test plan
- Reset/cadence: `INIT_DIVS`={4,6,1}, `en`=1 after release.
  - ch0 `tick` follows edges 4, 8, 12; `sq` pattern is 1,0,0,1.
  - ch1: `sq` is high for 3 cycles and low for 3.
  - ch2: `tick`=`sq`=1 every cycle.
- Odd divisor: write ch0 D=5.
  - After the next wrap, `sq` is high for 3 cycles and low for 2.
  - `tick` period is 5.
  - `pending` is 1 from the write until that wrap.
- Write at wrap: `cfg_we` (ch0, D=8) on the exact edge where `cnt`=3 with D=4.
  - One more D=4 period runs, then D=8 applies.
  - `pending` stays 1 through the first wrap.
- Error: write `cfg_div`=0 and write `cfg_ch`=3 with `NUM_CH`=3.
  - `cfg_err` pulses once per write.
  - Divisors and `pending` are unchanged.
- `en`/`sync`:
  - Hold `en`=0 for 10 cycles mid-period: no `tick`, `cnt` frozen, the cadence resumes seamlessly.
  - Pulse `sync` with channels out of phase: all `tick`=1 in the next cycle, then phase-aligned from there.
- Async reset mid-operation: assert `reset`=0 between clock edges.
  - `tick`/`sq`/`pending` go to 0 immediately.
  - After release, the edge-4 first tick reappears with the `INIT_DIVS` values.
